// File: rtl/ping_tx_pkg.sv
// Shared types and default timing for the ultrasonic ping transmitter.
package ping_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BURST,
    BLANK,
    LISTEN,
    HOLDOFF
  } state_e;

  localparam int DEF_HALF_PERIOD    = 391;
  localparam int DEF_BURST_CYCLES   = 8;
  localparam int DEF_BLANK_CYCLES   = 31250;
  localparam int DEF_TIMEOUT_CYCLES = 1562500;
  localparam int DEF_HOLDOFF_CYCLES = 312500;

  localparam int STATS_W = 16;

  // Width of a counter that holds 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ping_tx_burst_gen.sv
// Square-wave burst generator: BURST_CYCLES full periods of HALF_PERIOD-cycle halves while en is high.
module burst_gen
  import ping_tx_pkg::*;
#(
  parameter int HALF_PERIOD  = DEF_HALF_PERIOD,
  parameter int BURST_CYCLES = DEF_BURST_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tx_p,
  output logic tx_n,
  output logic done
);

  localparam int NHALF = 2 * BURST_CYCLES;
  localparam int HW    = cnt_w(HALF_PERIOD);
  localparam int NW    = cnt_w(NHALF);

  logic [HW-1:0] half_cnt_q, half_cnt_d;
  logic [NW-1:0] half_idx_q, half_idx_d;
  logic          half_wrap;
  logic          last_half;

  assign half_wrap = (half_cnt_q == HW'(HALF_PERIOD - 1));
  assign last_half = (half_idx_q == NW'(NHALF - 1));

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    half_cnt_d = '0;
    half_idx_d = '0;
    if (en) begin
      if (half_wrap) begin
        half_idx_d = last_half ? '0 : half_idx_q + 1'b1;
      end else begin
        half_cnt_d = half_cnt_q + 1'b1;
        half_idx_d = half_idx_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_cnt_q <= '0;
      half_idx_q <= '0;
    end else begin
      half_cnt_q <= half_cnt_d;
      half_idx_q <= half_idx_d;
    end
  end

  // Even halves drive the positive leg; gating with en keeps both legs low outside the burst.
  assign tx_p = en & ~half_idx_q[0];
  assign tx_n = en &  half_idx_q[0];
  assign done = en & half_wrap & last_half;

endmodule

// File: rtl/ping_tx.sv
// Ultrasonic ping transmitter: burst, ring-down blanking, listen with timeout, echo hold-off.
// Define PING_TX_STATS_EN to implement the ping_count/timeout_count statistics counters.
module ping_tx
  import ping_tx_pkg::*;
#(
  parameter int HALF_PERIOD    = DEF_HALF_PERIOD,
  parameter int BURST_CYCLES   = DEF_BURST_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fire,
  input  logic        auto_en,
  input  logic        math_complete,
  output logic        tx_p,
  output logic        tx_n,
  output logic        start_seq,
  output logic        rx_blank,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] ping_count,
  output logic [15:0] timeout_count
);

  localparam int PHASE_MAX = (BLANK_CYCLES > HOLDOFF_CYCLES) ? BLANK_CYCLES : HOLDOFF_CYCLES;
  localparam int PW        = cnt_w(PHASE_MAX);
  localparam int TW        = cnt_w(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  logic [PW-1:0] phase_cnt_q, phase_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout_q, timeout_d;
  logic          burst_en;
  logic          burst_done;
  logic          expired;

  assign burst_en = (state_q == BURST);
  assign expired  = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  burst_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .BURST_CYCLES(BURST_CYCLES)
  ) u_burst_gen (
    .clk  (CLK),
    .rst_n(RST),
    .en   (burst_en),
    .tx_p (tx_p),
    .tx_n (tx_n),
    .done (burst_done)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      phase_cnt_q <= '0;
      tmo_cnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  // The timeout counter spans BURST..LISTEN so the limit is measured from time zero, not from LISTEN.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q + 1'b1;
    tmo_cnt_d   = '0;
    timeout_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (fire || auto_en) state_d = BURST;
      end
      BURST: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (expired) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else if (burst_done) begin
          state_d = BLANK;
        end
      end
      BLANK: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        if (expired) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end else if (phase_cnt_q == PW'(BLANK_CYCLES - 1)) begin
          state_d = LISTEN;
        end
      end
      LISTEN: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // A result arriving on the expiry cycle still counts as a completed ping.
        if (math_complete) begin
          state_d = HOLDOFF;
        end else if (expired) begin
          state_d   = HOLDOFF;
          timeout_d = 1'b1;
        end
      end
      HOLDOFF: begin
        if (phase_cnt_q == PW'(HOLDOFF_CYCLES - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) phase_cnt_d = '0;
  end

  always_comb begin
    start_seq = (state_q == BURST) && (tmo_cnt_q == '0);
    rx_blank  = (state_q == BURST) || (state_q == BLANK);
    busy      = (state_q != IDLE);
    timeout   = timeout_q;
  end

`ifdef PING_TX_STATS_EN
  logic               complete_evt;
  logic [STATS_W-1:0] ping_cnt_q, ping_cnt_d;
  logic [STATS_W-1:0] tmo_stat_q, tmo_stat_d;

  assign complete_evt = (state_q == LISTEN) && math_complete;

  always_comb begin
    ping_cnt_d = ping_cnt_q;
    tmo_stat_d = tmo_stat_q;
    if (complete_evt && (ping_cnt_q != '1)) ping_cnt_d = ping_cnt_q + 1'b1;
    if (timeout_d && (tmo_stat_q != '1))    tmo_stat_d = tmo_stat_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ping_cnt_q <= '0;
      tmo_stat_q <= '0;
    end else begin
      ping_cnt_q <= ping_cnt_d;
      tmo_stat_q <= tmo_stat_d;
    end
  end

  assign ping_count    = ping_cnt_q;
  assign timeout_count = tmo_stat_q;
`else
  assign ping_count    = '0;
  assign timeout_count = '0;
`endif

endmodule

// File: tb/tb_ping_tx.sv
// Self-checking bench for ping_tx with shortened timing; per-cycle output scoreboard plus corner sequences.
module tb_ping_tx;

  localparam int HP        = 4;
  localparam int BC        = 2;
  localparam int BL        = 10;
  localparam int TO        = 100;
  localparam int HO        = 20;
  localparam int BURST_LEN = 2 * BC * HP;
  localparam int LISTEN_K  = BURST_LEN + BL;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fire = 1'b0;
  logic        auto_en = 1'b0;
  logic        math_complete = 1'b0;
  logic        tx_p, tx_n, start_seq, rx_blank, busy, timeout;
  logic [15:0] ping_count, timeout_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         k;
    logic [5:0] vec;
  } exp_t;

  typedef struct {
    string name;
    int    complete_k;
    int    spur_k;
    int    fire_k;
    int    ping_exp;
    int    tmo_exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[5];

  ping_tx #(
    .HALF_PERIOD   (HP),
    .BURST_CYCLES  (BC),
    .BLANK_CYCLES  (BL),
    .TIMEOUT_CYCLES(TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .CLK          (clk),
    .RST          (rst_n),
    .fire         (fire),
    .auto_en      (auto_en),
    .math_complete(math_complete),
    .tx_p         (tx_p),
    .tx_n         (tx_n),
    .start_seq    (start_seq),
    .rx_blank     (rx_blank),
    .busy         (busy),
    .timeout      (timeout),
    .ping_count   (ping_count),
    .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] act_vec();
    return {tx_p, tx_n, start_seq, rx_blank, busy, timeout};
  endfunction

  function automatic int stat(input int n);
`ifdef PING_TX_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic bit completes(input int complete_k);
    return (complete_k >= LISTEN_K) && (complete_k <= TO - 1);
  endfunction

  function automatic int hold_start(input int complete_k);
    return completes(complete_k) ? complete_k + 1 : TO;
  endfunction

  // Expected {tx_p,tx_n,start_seq,rx_blank,busy,timeout} k cycles after burst start.
  function automatic logic [5:0] model(input int k, input int complete_k);
    int   hs;
    logic p;
    logic in_burst;
    hs       = hold_start(complete_k);
    in_burst = (k < BURST_LEN);
    p        = in_burst && (((k / HP) % 2) == 0);
    if (k < hs)
      return {p, in_burst && !p, k == 0, k < LISTEN_K, 1'b1, 1'b0};
    else if (k < hs + HO)
      return {4'b0000, 1'b1, (k == hs) && !completes(complete_k)};
    else
      return 6'b000000;
  endfunction

  task automatic push_expect(input int complete_k);
    exp_t e;
    for (int k = 0; k <= hold_start(complete_k) + HO; k++) begin
      e.k   = k;
      e.vec = model(k, complete_k);
      sb_q.push_back(e);
    end
  endtask

  task automatic run_ping(input vec_t v);
    exp_t e;
    int   k;
    fire = 1'b1;
    push_expect(v.complete_k);
    tick();
    fire = 1'b0;
    k = 0;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("%s_k%0d", v.name, e.k), act_vec(), e.vec);
      math_complete = (k == v.complete_k) || (k == v.spur_k);
      fire          = (k == v.fire_k);
      tick();
      k++;
    end
    math_complete = 1'b0;
    fire          = 1'b0;
    check({v.name, "_ping_count"}, ping_count, stat(v.ping_exp));
    check({v.name, "_timeout_count"}, timeout_count, stat(v.tmo_exp));
  endtask

  initial begin
    int  n;
    int  prev;
    int  seen;
    bit  found;

    tbl[0] = '{"nominal",      40, -1,  5, 1, 0};
    tbl[1] = '{"no_result",    -1, 20, 50, 1, 1};
    tbl[2] = '{"tie_expiry",   99, -1, -1, 2, 1};
    tbl[3] = '{"first_listen", 26, 25, 46, 3, 1};
    tbl[4] = '{"late_result", 100, -1, 30, 3, 2};

    #12;
    check("reset_outputs", act_vec(), 6'b0);
    check("reset_ping_count", ping_count, 0);
    check("reset_timeout_count", timeout_count, 0);
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_no_fire", act_vec(), 6'b0);

    foreach (tbl[i]) run_ping(tbl[i]);

    // Auto-repeat: result 30 cycles after each burst start gives a 52-cycle ping period.
    auto_en = 1'b1;
    n    = 0;
    prev = 0;
    for (int p = 0; p < 3; p++) begin
      found = 1'b0;
      for (int w = 0; w < 200 && !found; w++) begin
        if (start_seq) found = 1'b1;
        else begin
          tick();
          n++;
        end
      end
      check($sformatf("auto_start_seen_%0d", p), found, 1);
      if (p > 0) check($sformatf("auto_period_%0d", p), n - prev, 52);
      prev = n;
      if (p == 2) auto_en = 1'b0;
      for (int r = 0; r <= 30; r++) begin
        math_complete = (r == 30);
        fire          = (r == 10);
        tick();
        n++;
      end
      math_complete = 1'b0;
      fire          = 1'b0;
    end
    found = 1'b0;
    for (int w = 0; w < 100 && !found; w++) begin
      if (!busy) found = 1'b1;
      else tick();
    end
    check("auto_returns_idle", found, 1);
    seen = 0;
    for (int w = 0; w < 60; w++) begin
      if (start_seq) seen++;
      tick();
    end
    check("auto_off_no_restart", seen, 0);
    check("auto_ping_count", ping_count, stat(6));
    check("auto_timeout_count", timeout_count, stat(2));

    // Reset in the middle of the burst must kill the drive without waiting for a clock edge.
    fire = 1'b1;
    tick();
    fire = 1'b0;
    repeat (5) tick();
    check("midburst_active", {tx_p, tx_n, busy}, 3'b011);
    rst_n = 1'b0;
    #1;
    check("midburst_reset_outputs", act_vec(), 6'b0);
    check("midburst_reset_ping_count", ping_count, 0);
    check("midburst_reset_timeout_count", timeout_count, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_reset_idle", act_vec(), 6'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
